// File: rtl/pong_pkg.sv
//==============================================================================
// Module : pong_pkg
// Brief  : Shared screen geometry, speeds, colours and FSM states for pong_anim.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package pong_pkg;

  localparam logic [10:0] c_SCREEN_W  = 11'd640;
  localparam logic [10:0] c_SCREEN_H  = 11'd480;
  localparam logic [9:0]  c_REFRESH_Y = 10'd481;

  localparam logic [10:0] c_WALL_XL   = 11'd32;
  localparam logic [10:0] c_WALL_XR   = 11'd35;
  localparam logic [10:0] c_PAD_XL    = 11'd600;
  localparam logic [10:0] c_PAD_XR    = 11'd603;
  localparam logic [10:0] c_PAD_H     = 11'd72;
  localparam logic [10:0] c_PAD_TOP0  = 11'd204;
  localparam logic [10:0] c_PAD_STEP  = 11'd4;
  localparam logic [10:0] c_PAD_Y_MAX = 11'd475;

  localparam logic [10:0] c_BALL_SIZE = 11'd8;
  localparam logic [10:0] c_BALL_X0   = 11'd320;
  localparam logic [10:0] c_BALL_Y0   = 11'd240;
  localparam logic [10:0] c_Y_TOP_LIM = 11'd1;
  localparam logic [10:0] c_Y_BOT_LIM = 11'd478;

  localparam logic signed [9:0] c_BALL_V = 10'sd2;
  localparam logic signed [9:0] c_V_NEG  = -c_BALL_V;

  localparam logic [5:0]  c_MISS_FRAMES = 6'd60;

  localparam logic [11:0] c_RGB_BLACK = 12'h000;
  localparam logic [11:0] c_RGB_RED   = 12'hF00;
  localparam logic [11:0] c_RGB_GREEN = 12'h0F0;
  localparam logic [11:0] c_RGB_BLUE  = 12'h00F;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_MISS  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  function automatic logic in_span(input logic [10:0] v,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_frame_tick.sv
//==============================================================================
// Module : pong_frame_tick
// Brief  : One-clk refresh strobe at the first pixel of line 481.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pong_frame_tick (
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       refresh_tick
);
  import pong_pkg::*;

  // Gated by reset so a reset cycle can never also advance the animation.
  assign refresh_tick = !reset && pixel_tick &&
                        (pixel_x == 10'd0) && (pixel_y == c_REFRESH_Y);

endmodule

`default_nettype wire

// File: rtl/pong_anim.sv
//==============================================================================
// Module : pong_anim
// Brief  : Pong wall/paddle/ball animation with registered VGA colour output.
//          Optional paddle-hit score counter enabled by macro PONG_SCORE_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pong_anim (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       miss
`ifdef PONG_SCORE_EN
  ,
  output logic [7:0] score
`endif
);
  import pong_pkg::*;

  logic              w_refresh_tick;
  state_t            r_state, w_state_nxt;
  logic [10:0]       r_ball_x, r_ball_y, w_ball_x_nxt, w_ball_y_nxt;
  logic signed [9:0] r_vx, r_vy, w_vx_nxt, w_vy_nxt;
  logic [10:0]       r_pad_top, w_pad_top_nxt;
  logic [5:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic              r_miss, w_miss_nxt;
  logic [11:0]       r_rgb, w_rgb;
  logic [10:0]       w_px, w_py, w_ball_r, w_ball_b, w_pad_b;
  logic              w_hit, w_on_wall, w_on_pad, w_on_ball;
`ifdef PONG_SCORE_EN
  logic [7:0]        r_score, w_score_nxt;
`endif

  pong_frame_tick u_frame_tick (
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .refresh_tick (w_refresh_tick)
  );

  assign w_px     = {1'b0, pixel_x};
  assign w_py     = {1'b0, pixel_y};
  assign w_ball_r = r_ball_x + c_BALL_SIZE - 11'd1;
  assign w_ball_b = r_ball_y + c_BALL_SIZE - 11'd1;
  assign w_pad_b  = r_pad_top + c_PAD_H - 11'd1;

  assign w_hit = in_span(w_ball_r, c_PAD_XL, c_PAD_XR) &&
                 (w_ball_b >= r_pad_top) && (r_ball_y <= w_pad_b);

  always_comb begin
    w_state_nxt     = r_state;
    w_ball_x_nxt    = r_ball_x;
    w_ball_y_nxt    = r_ball_y;
    w_vx_nxt        = r_vx;
    w_vy_nxt        = r_vy;
    w_pad_top_nxt   = r_pad_top;
    w_frame_cnt_nxt = r_frame_cnt;
    w_miss_nxt      = 1'b0;
`ifdef PONG_SCORE_EN
    w_score_nxt     = r_score;
`endif
    if (w_refresh_tick) begin
      if (btn_up && !btn_down && (r_pad_top >= c_PAD_STEP))
        w_pad_top_nxt = r_pad_top - c_PAD_STEP;
      else if (btn_down && !btn_up && (w_pad_b <= c_PAD_Y_MAX))
        w_pad_top_nxt = r_pad_top + c_PAD_STEP;

      case (r_state)
        ST_PLAY: begin
          if (w_ball_r > c_SCREEN_W - 11'd1) begin
            w_state_nxt     = ST_MISS;
            w_frame_cnt_nxt = 6'd0;
            w_miss_nxt      = 1'b1;
`ifdef PONG_SCORE_EN
            w_score_nxt     = 8'd0;
`endif
          end else begin
            // Vertical and horizontal decisions are independent so corner hits apply both.
            if (r_ball_y <= c_Y_TOP_LIM)
              w_vy_nxt = c_BALL_V;
            else if (w_ball_b >= c_Y_BOT_LIM)
              w_vy_nxt = c_V_NEG;
            if (r_ball_x <= c_WALL_XR)
              w_vx_nxt = c_BALL_V;
            else if (w_hit) begin
              w_vx_nxt = c_V_NEG;
`ifdef PONG_SCORE_EN
              if (r_score != 8'hFF)
                w_score_nxt = r_score + 8'd1;
`endif
            end
            w_ball_x_nxt = r_ball_x + {w_vx_nxt[9], w_vx_nxt};
            w_ball_y_nxt = r_ball_y + {w_vy_nxt[9], w_vy_nxt};
          end
        end
        ST_MISS: begin
          if (r_frame_cnt == c_MISS_FRAMES - 6'd1) begin
            w_state_nxt     = ST_SERVE;
            w_frame_cnt_nxt = 6'd0;
            w_ball_x_nxt    = c_BALL_X0;
            w_ball_y_nxt    = c_BALL_Y0;
            w_vx_nxt        = c_V_NEG;
            w_vy_nxt        = c_BALL_V;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 6'd1;
          end
        end
        ST_SERVE: w_state_nxt = ST_PLAY;
        default:  w_state_nxt = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_PLAY;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ball_x    <= c_BALL_X0;
      r_ball_y    <= c_BALL_Y0;
      r_vx        <= c_BALL_V;
      r_vy        <= c_BALL_V;
      r_pad_top   <= c_PAD_TOP0;
      r_frame_cnt <= 6'd0;
      r_miss      <= 1'b0;
`ifdef PONG_SCORE_EN
      r_score     <= 8'd0;
`endif
    end else begin
      r_ball_x    <= w_ball_x_nxt;
      r_ball_y    <= w_ball_y_nxt;
      r_vx        <= w_vx_nxt;
      r_vy        <= w_vy_nxt;
      r_pad_top   <= w_pad_top_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_miss      <= w_miss_nxt;
`ifdef PONG_SCORE_EN
      r_score     <= w_score_nxt;
`endif
    end
  end

  assign w_on_wall = in_span(w_px, c_WALL_XL, c_WALL_XR) && (w_py <= c_SCREEN_H - 11'd1);
  assign w_on_pad  = in_span(w_px, c_PAD_XL, c_PAD_XR) && in_span(w_py, r_pad_top, w_pad_b);
  assign w_on_ball = (r_state == ST_PLAY) &&
                     in_span(w_px, r_ball_x, w_ball_r) && in_span(w_py, r_ball_y, w_ball_b);

  always_comb begin
    w_rgb = c_RGB_BLACK;
    if (video_on) begin
      if (w_on_wall)
        w_rgb = c_RGB_RED;
      else if (w_on_pad)
        w_rgb = c_RGB_GREEN;
      else if (w_on_ball)
        w_rgb = c_RGB_BLUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_rgb <= c_RGB_BLACK;
    else if (pixel_tick)
      r_rgb <= w_rgb;
  end

  assign r    = r_rgb[11:8];
  assign g    = r_rgb[7:4];
  assign b    = r_rgb[3:0];
  assign miss = r_miss;
`ifdef PONG_SCORE_EN
  assign score = r_score;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pong_anim.sv
//==============================================================================
// Module : tb_pong_anim
// Brief  : Scoreboard bench for pong_anim: directed frames and pixel probes.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pong_anim;

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_GREEN = 12'h0F0;
  localparam logic [11:0] C_BLUE  = 12'h00F;

  logic       clk = 1'b0;
  logic       reset, pixel_tick, video_on, btn_up, btn_down;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] r, g, b;
  logic       miss;
`ifdef PONG_SCORE_EN
  logic [7:0] score;
`endif

  int errors = 0;
  int checks = 0;
  int e_rt   = 0;
  int rt_count = 0;
  logic [7:0] e_score = 8'd0;
  logic mon_valid = 1'b0;

  logic [11:0] q_rgb[$];
  logic        q_miss[$];
  int          q_rt[$];
  logic [7:0]  q_score[$];
  string       q_tag[$];

  logic [11:0] m_rgb;
  logic        m_miss;
  int          m_rt;
  logic [7:0]  m_score;
  string       m_tag;

  pong_anim dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .r          (r),
    .g          (g),
    .b          (b),
    .miss       (miss)
`ifdef PONG_SCORE_EN
    ,
    .score      (score)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mon_valid <= pixel_tick;
    if (dut.w_refresh_tick) rt_count <= rt_count + 1;
  end

  // Monitor: every pixel_tick yields one registered output a clock later.
  always @(negedge clk) begin
    if (mon_valid) begin
      if (q_rgb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: output present with nothing expected");
      end else begin
        m_rgb = q_rgb.pop_front();
        m_miss = q_miss.pop_front();
        m_rt = q_rt.pop_front();
        m_score = q_score.pop_front();
        m_tag = q_tag.pop_front();
        checks++;
        if ({r, g, b} !== m_rgb) begin
          errors++;
          $display("FAIL %s rgb: got %03h expected %03h", m_tag, {r, g, b}, m_rgb);
        end
        checks++;
        if (miss !== m_miss) begin
          errors++;
          $display("FAIL %s miss: got %0b expected %0b", m_tag, miss, m_miss);
        end
        checks++;
        if (rt_count != m_rt) begin
          errors++;
          $display("FAIL %s refresh_count: got %0d expected %0d", m_tag, rt_count, m_rt);
        end
`ifdef PONG_SCORE_EN
        checks++;
        if (score !== m_score) begin
          errors++;
          $display("FAIL %s score: got %0d expected %0d", m_tag, score, m_score);
        end
`endif
      end
    end
  end

  task automatic drive(input int x, input int y, input logic von, input logic up,
                       input logic dn, input logic tick, input logic [11:0] ergb,
                       input logic emiss, input logic inc, input string tag);
    @(negedge clk);
    pixel_x = x[9:0];
    pixel_y = y[9:0];
    video_on = von;
    btn_up = up;
    btn_down = dn;
    pixel_tick = tick;
    if (inc) e_rt++;
    if (tick) begin
      q_rgb.push_back(ergb);
      q_miss.push_back(emiss);
      q_rt.push_back(e_rt);
      q_score.push_back(e_score);
      q_tag.push_back(tag);
    end
    @(negedge clk);
    pixel_tick = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] ergb, input string tag);
    drive(x, y, 1'b1, 1'b0, 1'b0, 1'b1, ergb, 1'b0, 1'b0, tag);
  endtask

  task automatic frame(input logic up, input logic dn, input logic emiss);
    drive(0, 481, 1'b0, up, dn, 1'b1, C_BLACK, emiss, 1'b1, "frame");
  endtask

  task automatic frames(input int n, input logic up, input logic dn);
    for (int i = 0; i < n; i++) frame(up, dn, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; pixel_x = '0; pixel_y = '0;
    repeat (3) @(negedge clk);
    probe(32, 100, C_BLACK, "rst_rgb");
    drive(0, 481, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "rst_tick");
    reset = 1'b0;

    probe(320, 240, C_BLUE,  "ball0");
    probe(319, 240, C_BLACK, "ball0_left");
    probe(327, 247, C_BLUE,  "ball0_corner");
    probe(328, 240, C_BLACK, "ball0_right");
    probe(32, 0,    C_RED,   "wall_tl");
    probe(35, 479,  C_RED,   "wall_br");
    probe(31, 10,   C_BLACK, "wall_left");
    probe(36, 10,   C_BLACK, "wall_right");
    probe(600, 204, C_GREEN, "pad_top");
    probe(603, 275, C_GREEN, "pad_bot");
    probe(600, 203, C_BLACK, "pad_above");
    probe(600, 276, C_BLACK, "pad_below");
    probe(604, 210, C_BLACK, "pad_right");
    drive(32, 100, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "video_off_wall");

    // Near-miss frame strobes must not count or move anything.
    drive(0, 481, 1'b0, 1'b0, 1'b0, 1'b0, C_BLACK, 1'b0, 1'b0, "no_tick");
    drive(1, 481, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "x1");
    drive(0, 480, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "y480");
    probe(320, 240, C_BLUE, "ball_still");

    frame(1'b0, 1'b0, 1'b0);                       // k=1
    probe(322, 242, C_BLUE,  "ball1");
    probe(321, 242, C_BLACK, "ball1_left");
    probe(322, 241, C_BLACK, "ball1_above");

    frames(5, 1'b1, 1'b1);                         // k=6, both buttons
    probe(600, 204, C_GREEN, "both_top");
    probe(600, 203, C_BLACK, "both_above");
    probe(600, 276, C_BLACK, "both_below");

    frames(40, 1'b0, 1'b1);                        // k=46, paddle 364
    probe(600, 364, C_GREEN, "down_top");
    probe(600, 363, C_BLACK, "down_above");
    probe(600, 435, C_GREEN, "down_bot");
    probe(600, 436, C_BLACK, "down_below");
    probe(412, 332, C_BLUE,  "ball46");

    frames(71, 1'b0, 1'b0);                        // k=117, bottom bounce
    probe(554, 470, C_BLUE,  "bounce_bot");
    probe(554, 469, C_BLACK, "bounce_bot_above");
    frame(1'b0, 1'b0, 1'b0);                       // k=118
    probe(556, 468, C_BLUE,  "going_up");
    probe(556, 476, C_BLACK, "going_up_below");

    frames(19, 1'b0, 1'b0);                        // k=137, (594,430)
    probe(594, 430, C_BLUE, "pre_hit");
    e_score = 8'd1;
    frame(1'b0, 1'b0, 1'b0);                       // paddle hit
    probe(592, 428, C_BLUE,  "post_hit");
    probe(591, 428, C_BLACK, "post_hit_left");
    frame(1'b0, 1'b0, 1'b0);
    probe(590, 426, C_BLUE, "leaving_pad");

    frames(278, 1'b0, 1'b0);                       // top bounce on the way, ball (34,130)
    probe(36, 130, C_BLUE, "at_wall");
    probe(35, 130, C_RED,  "wall_over_ball");
    frame(1'b0, 1'b0, 1'b0);
    probe(36, 132, C_BLUE, "wall_bounce");
    probe(35, 132, C_RED,  "wall_bounce_wall");

    frames(299, 1'b0, 1'b0);                       // ball (634,214), paddle missed
    probe(634, 214, C_BLUE,  "pre_miss");
    probe(633, 214, C_BLACK, "pre_miss_left");
    e_score = 8'd0;
    frame(1'b0, 1'b0, 1'b1);                       // PLAY -> MISS
    probe(634, 214, C_BLACK, "miss_hidden");

    frames(59, 1'b0, 1'b0);
    probe(320, 240, C_BLACK, "miss59_center");
    probe(634, 214, C_BLACK, "miss59_old");
    frame(1'b0, 1'b0, 1'b0);                       // 60th -> SERVE
    probe(320, 240, C_BLACK, "serve_hidden");
    frame(1'b0, 1'b0, 1'b0);                       // SERVE -> PLAY
    probe(320, 240, C_BLUE, "served");
    frame(1'b0, 1'b0, 1'b0);
    probe(318, 242, C_BLUE,  "serve_move");
    probe(317, 242, C_BLACK, "serve_move_left");
    probe(326, 242, C_BLACK, "serve_move_right");

    // Reset coinciding with a frame strobe.
    reset = 1'b1;
    drive(0, 481, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "rst_mid");
    reset = 1'b0;
    probe(320, 240, C_BLUE,  "rst_ball");
    probe(600, 204, C_GREEN, "rst_pad");
    probe(600, 400, C_BLACK, "rst_pad_old");

    frames(60, 1'b1, 1'b0);                        // paddle up to 0
    probe(600, 0,  C_GREEN, "up_top");
    probe(600, 71, C_GREEN, "up_bot");
    probe(600, 72, C_BLACK, "up_below");
    frames(3, 1'b1, 1'b1);
    probe(600, 72, C_BLACK, "up_both_below");
    probe(446, 366, C_BLUE, "ball_after_up");

    drive(33, 10,   1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "voff_wall");
    drive(601, 10,  1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "voff_pad");
    drive(446, 366, 1'b0, 1'b0, 1'b0, 1'b1, C_BLACK, 1'b0, 1'b0, "voff_ball");

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
